// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences TLBP/TLBR/TLBWI from WB, drives the TLB ports and CP0 strobes,
// and stalls the pipeline until the operation is done.
module tlb_op_ctrl #(
    parameter int TLBNUM = 16,
    parameter int IDX_W  = 4
) (
    input  logic             cp0_clk,
    input  logic             reset,
    input  logic             op_req,
    input  logic [1:0]       op_type,
    input  logic [31:0]      op_pc,
    input  logic             flush,
    input  logic [IDX_W-1:0] cp0_index,
    input  logic [31:0]      cp0_entryhi,
    input  logic [31:0]      cp0_entrylo0,
    input  logic [31:0]      cp0_entrylo1,
    output logic [18:0]      s_vpn2,
    output logic [7:0]       s_asid,
    input  logic             s_found,
    input  logic [IDX_W-1:0] s_index,
    output logic [IDX_W-1:0] r_index,
    input  logic [77:0]      r_data,
    output logic             we,
    output logic [IDX_W-1:0] w_index,
    output logic [77:0]      w_data,
    output logic             is_TLBP,
    output logic             index_write_p,
    output logic [IDX_W-1:0] index_write_index,
    output logic             is_TLBR,
    output logic [77:0]      TLB_rdata,
    output logic             stall,
    output logic             op_done,
    output logic             refetch,
    output logic [31:0]      refetch_pc
);
    if (TLBNUM > (1 << IDX_W)) begin : g_bad_cfg
        $error("TLBNUM does not fit in IDX_W index bits");
    end

    typedef enum logic [2:0] {IDLE, SRCH, RD, WR, DONE} state_t;
    state_t state, state_nx;

    logic [1:0]       typ;
    logic [31:0]      pc;
    logic [IDX_W-1:0] idx;
    logic [18:0]      vpn2;
    logic [7:0]       asid;
    logic [25:0]      lo0, lo1;
    logic             accept;
    logic             unused;

    assign unused = ^{cp0_entryhi[12:8], cp0_entrylo0[31:26], cp0_entrylo1[31:26]};
    assign accept = state == IDLE && op_req && op_type != 2'b00 && !flush;

    always_comb begin
        state_nx = state;
        state_nx = state == IDLE ? (accept ? (op_type == 2'b01 ? SRCH :
                                              op_type == 2'b10 ? RD : WR) : IDLE) :
                   state inside {SRCH, RD, WR} ? DONE : IDLE;
    end

    always_ff @(posedge cp0_clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge cp0_clk or posedge reset) begin
        if (reset) begin
            typ               <= '0;
            pc                <= '0;
            idx               <= '0;
            vpn2              <= '0;
            asid              <= '0;
            lo0               <= '0;
            lo1               <= '0;
            stall             <= 1'b0;
            is_TLBP           <= 1'b0;
            index_write_p     <= 1'b0;
            index_write_index <= '0;
            is_TLBR           <= 1'b0;
            TLB_rdata         <= '0;
        end else begin
            if (accept) begin
                typ  <= op_type;
                pc   <= op_pc;
                idx  <= cp0_index;
                vpn2 <= cp0_entryhi[31:13];
                asid <= cp0_entryhi[7:0];
                lo0  <= cp0_entrylo0[25:0];
                lo1  <= cp0_entrylo1[25:0];
            end
            stall             <= state_nx != IDLE;
            is_TLBP           <= state == SRCH;
            index_write_p     <= state == SRCH && !s_found;
            index_write_index <= state == SRCH ? (s_found ? s_index : idx) : '0;
            is_TLBR           <= state == RD;
            if (state == RD) TLB_rdata <= r_data;
        end
    end

    // Search/read ports are live from the latched operands; the TLB samples them only in SRCH/RD.
    assign s_vpn2     = vpn2;
    assign s_asid     = asid;
    assign r_index    = idx;
    assign we         = state == WR;
    assign w_index    = we ? idx : '0;
    assign w_data     = we ? {vpn2, asid, lo0[0] & lo1[0], lo0[25:1], lo1[25:1]} : '0;
    assign op_done    = state == DONE;
    assign refetch    = op_done && typ != 2'b01;
    assign refetch_pc = refetch ? pc + 32'd4 : '0;
endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb_tlb_op_ctrl: directed vectors for tlb_op_ctrl against a small behavioural TLB array.
module tb_tlb_op_ctrl;
    logic        clk = 1'b0, reset = 1'b1;
    logic        op_req = 1'b0, flush = 1'b0;
    logic [1:0]  op_type = '0;
    logic [31:0] op_pc = '0, cp0_entryhi = '0, cp0_entrylo0 = '0, cp0_entrylo1 = '0;
    logic [3:0]  cp0_index = '0;
    logic [18:0] s_vpn2;
    logic [7:0]  s_asid;
    logic        s_found;
    logic [3:0]  s_index, r_index, w_index, index_write_index;
    logic [77:0] r_data, w_data, TLB_rdata;
    logic        we, is_TLBP, index_write_p, is_TLBR, stall, op_done, refetch;
    logic [31:0] refetch_pc;
    int total = 0, bad = 0;

    logic [77:0] tlb [16];

    tlb_op_ctrl #(.TLBNUM(16), .IDX_W(4)) dut (
        .cp0_clk(clk), .reset(reset), .op_req(op_req), .op_type(op_type), .op_pc(op_pc),
        .flush(flush), .cp0_index(cp0_index), .cp0_entryhi(cp0_entryhi),
        .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1), .s_vpn2(s_vpn2),
        .s_asid(s_asid), .s_found(s_found), .s_index(s_index), .r_index(r_index),
        .r_data(r_data), .we(we), .w_index(w_index), .w_data(w_data), .is_TLBP(is_TLBP),
        .index_write_p(index_write_p), .index_write_index(index_write_index),
        .is_TLBR(is_TLBR), .TLB_rdata(TLB_rdata), .stall(stall), .op_done(op_done),
        .refetch(refetch), .refetch_pc(refetch_pc)
    );

    always #5 clk = ~clk;

    // Lowest matching index wins; G entries ignore ASID.
    always_comb begin
        s_found = 1'b0;
        s_index = '0;
        for (int i = 15; i >= 0; i--) begin
            if (tlb[i][77:59] == s_vpn2 && (tlb[i][50] || tlb[i][58:51] == s_asid)) begin
                s_found = 1'b1;
                s_index = 4'(i);
            end
        end
    end
    assign r_data = tlb[r_index];
    always @(posedge clk) if (we) tlb[w_index] <= w_data;

    task automatic chk(input string name, input logic [77:0] act, input logic [77:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] pc;
        logic [3:0]  idx;
        logic [31:0] ehi, lo0, lo1;
        logic        p;
        logic [3:0]  widx;
        logic [77:0] data;
        logic        rf;
        logic [31:0] rpc;
    } vec_t;

    vec_t vt [6];
    localparam logic [77:0] E5 = {19'h00201, 8'h03, 1'b0, 25'h0001111, 25'h0002222};
    localparam logic [77:0] E7 = {19'h12345, 8'hA5, 1'b1, 25'h1ABCDEF, 25'h0123456};
    localparam logic [77:0] WD = {19'h40000, 8'h11, 1'b0, 25'h0000023, 25'h0000043};

    task automatic req(input vec_t v);
        @(negedge clk);
        op_req = 1'b1; op_type = v.op; op_pc = v.pc; cp0_index = v.idx;
        cp0_entryhi = v.ehi; cp0_entrylo0 = v.lo0; cp0_entrylo1 = v.lo1;
    endtask

    task automatic do_op(input vec_t v, input string tag);
        req(v);
        @(posedge clk); #1;
        chk({tag, ".stall1"}, 78'(stall), 78'd1);
        chk({tag, ".done1"}, 78'(op_done), 78'd0);
        if (v.op == 2'b01) begin
            chk({tag, ".s_vpn2"}, 78'(s_vpn2), 78'(v.ehi[31:13]));
            chk({tag, ".s_asid"}, 78'(s_asid), 78'(v.ehi[7:0]));
        end
        if (v.op == 2'b10) chk({tag, ".r_index"}, 78'(r_index), 78'(v.idx));
        chk({tag, ".we"}, 78'(we), 78'(v.op == 2'b11));
        if (v.op == 2'b11) begin
            chk({tag, ".w_index"}, 78'(w_index), 78'(v.idx));
            chk({tag, ".w_data"}, w_data, v.data);
        end
        @(posedge clk); #1;
        chk({tag, ".done"}, 78'(op_done), 78'd1);
        chk({tag, ".stall2"}, 78'(stall), 78'd1);
        chk({tag, ".we2"}, 78'(we), 78'd0);
        chk({tag, ".is_TLBP"}, 78'(is_TLBP), 78'(v.op == 2'b01));
        chk({tag, ".is_TLBR"}, 78'(is_TLBR), 78'(v.op == 2'b10));
        chk({tag, ".refetch"}, 78'(refetch), 78'(v.rf));
        if (v.rf) chk({tag, ".refetch_pc"}, 78'(refetch_pc), 78'(v.rpc));
        if (v.op == 2'b01) begin
            chk({tag, ".p"}, 78'(index_write_p), 78'(v.p));
            chk({tag, ".widx"}, 78'(index_write_index), 78'(v.widx));
        end
        if (v.op == 2'b10) chk({tag, ".rdata"}, TLB_rdata, v.data);
        op_req = 1'b0; op_type = 2'b00;
        @(posedge clk); #1;
        chk({tag, ".stall0"}, 78'(stall), 78'd0);
        chk({tag, ".done0"}, 78'(op_done), 78'd0);
        chk({tag, ".strobes0"}, 78'({is_TLBP, is_TLBR, we, refetch}), 78'd0);
    endtask

    task automatic idle_check(input string tag);
        @(posedge clk); #1;
        chk({tag, ".stall"}, 78'(stall), 78'd0);
        chk({tag, ".done"}, 78'(op_done), 78'd0);
        chk({tag, ".strobes"}, 78'({is_TLBP, is_TLBR, we, refetch}), 78'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) tlb[i] = {19'h7FFF0 + 19'(i), 8'hFF, 1'b0, 50'd0};
        tlb[5] = E5;
        tlb[7] = E7;
        vt[0] = '{2'b01, 32'h0000_1000, 4'd0, 32'h0040_2003, 32'd0, 32'd0, 1'b0, 4'd5, 78'd0, 1'b0, 32'd0};
        vt[1] = '{2'b01, 32'h0000_1004, 4'd9, 32'h1234_5003, 32'd0, 32'd0, 1'b1, 4'd9, 78'd0, 1'b0, 32'd0};
        vt[2] = '{2'b11, 32'hBFC0_0100, 4'd3, 32'h8000_0011, 32'h47, 32'h86, 1'b0, 4'd0, WD, 1'b1, 32'hBFC0_0104};
        vt[3] = '{2'b10, 32'h8000_1000, 4'd7, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0, E7, 1'b1, 32'h8000_1004};
        vt[4] = '{2'b10, 32'hFFFF_FFFC, 4'd3, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0, WD, 1'b1, 32'h0000_0000};
        vt[5] = '{2'b01, 32'h0000_2000, 4'd1, 32'h8000_0011, 32'd0, 32'd0, 1'b0, 4'd3, 78'd0, 1'b0, 32'd0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst.outs", 78'({stall, op_done, we, is_TLBP, is_TLBR, refetch, index_write_p}), 78'd0);
        chk("rst.rdata", TLB_rdata, 78'd0);
        chk("rst.rpc", 78'(refetch_pc), 78'd0);
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < 6; i++) do_op(vt[i], $sformatf("vec%0d", i));

        repeat (5) @(posedge clk);
        #1 chk("rdata.hold", TLB_rdata, WD);

        // Simultaneous flush blocks acceptance.
        @(negedge clk);
        op_req = 1'b1; op_type = 2'b01; cp0_entryhi = 32'h0040_2003; flush = 1'b1;
        idle_check("flush_req.a");
        idle_check("flush_req.b");
        @(negedge clk);
        flush = 1'b0; op_req = 1'b0;

        // A request with op_type 00 is not an operation.
        @(negedge clk);
        op_req = 1'b1; op_type = 2'b00;
        idle_check("op00.a");
        idle_check("op00.b");
        @(negedge clk) op_req = 1'b0;

        // Flush arriving after acceptance must not disturb the operation.
        req(vt[0]);
        @(posedge clk); #1;
        chk("late_flush.stall", 78'(stall), 78'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        chk("late_flush.done", 78'(op_done), 78'd1);
        chk("late_flush.is_TLBP", 78'(is_TLBP), 78'd1);
        chk("late_flush.widx", 78'(index_write_index), 78'd5);
        op_req = 1'b0; op_type = 2'b00; flush = 1'b0;
        idle_check("late_flush.end");

        // Asynchronous reset in the middle of a TLBWI.
        req('{2'b11, 32'h0000_3000, 4'd4, 32'h8000_0011, 32'h47, 32'h86, 1'b0, 4'd0, WD, 1'b1, 32'd0});
        @(posedge clk); #1;
        chk("rst_mid.we_before", 78'(we), 78'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid.we_async", 78'(we), 78'd0);
        chk("rst_mid.stall_async", 78'(stall), 78'd0);
        op_req = 1'b0; op_type = 2'b00;
        @(negedge clk) reset = 1'b0;
        idle_check("rst_mid.after.a");
        idle_check("rst_mid.after.b");
        chk("rst_mid.no_write", tlb[4], {19'h7FFF4, 8'hFF, 1'b0, 50'd0});
        do_op(vt[0], "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
